iter_shifter: RTL and testbench

//  Area-minimal multi-cycle shifter for the ALU; successor of the single-cycle
//  SLL/SRL/SRA block. Width-parametrised, adds ROL/ROR, shifts up to STEP bits
//  per clock, and talks to the issue/writeback stages via valid/ready handshakes.

---
 rtl/iter_shifter.sv | 130 +++++++++++++
 tb/tb_iter_shifter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle SLL/SRL/SRA/ROL/ROR shifter with valid/ready handshakes
module iter_shifter #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               op,
    input  logic [$clog2(XLEN)-1:0]  shamt,
    input  logic [XLEN-1:0]          data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          data_out
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW:0] STEP_K = (SHW+1)'(STEP);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [2:0]          op_r;
    logic                fill_r;
    logic [XLEN-1:0]     data_r;
    logic [SHW-1:0]      remaining;

    logic [SHW:0]        rem_ext;
    logic [SHW:0]        k;
    logic [SHW-1:0]      rem_next;
    logic [XLEN-1:0]     step_data;
    logic [2*XLEN-1:0]   dbl;

    assign rem_ext  = {1'b0, remaining};
    assign data_out = data_r;

    // One BUSY step: move by k = min(remaining, STEP); k never reaches XLEN since remaining < XLEN
    always_comb begin
        k         = (rem_ext < STEP_K) ? rem_ext : STEP_K;
        rem_next  = remaining - k[SHW-1:0];
        dbl       = '0;
        step_data = data_r;
        case (op_r)
            OP_SLL: step_data = data_r << k;
            OP_SRL: step_data = data_r >> k;
            OP_SRA: begin
                dbl       = {{XLEN{fill_r}}, data_r} >> k;
                step_data = dbl[XLEN-1:0];
            end
            OP_ROL: begin
                dbl       = {data_r, data_r} << k;
                step_data = dbl[2*XLEN-1:XLEN];
            end
            OP_ROR: begin
                dbl       = {data_r, data_r} >> k;
                step_data = dbl[XLEN-1:0];
            end
            default: step_data = data_r;
        endcase
    end

    // Control FSM with registered handshake outputs; rst beats flush, flush beats everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            data_r    <= '0;
            op_r      <= OP_SLL;
            fill_r    <= 1'b0;
            remaining <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r      <= op;
                        data_r    <= data_in;
                        remaining <= shamt;
                        fill_r    <= (op == OP_SRA) ? data_in[XLEN-1] : 1'b0;
                        in_ready  <= 1'b0;
                        if (shamt == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    data_r    <= step_data;
                    remaining <= rem_next;
                    if (rem_next == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - randomized self-checking bench for iter_shifter
module tb_iter_shifter;

    localparam int XLEN = 32;
    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;

    logic        s1_in_valid;
    logic        s1_in_ready;
    logic [2:0]  s1_op;
    logic [4:0]  s1_shamt;
    logic [31:0] s1_data_in;
    logic        s1_out_valid;
    logic        s1_out_ready;
    logic [31:0] s1_data_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iter_shifter #(.XLEN(XLEN), .STEP(STEP)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .shamt(shamt), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
    );

    iter_shifter #(.XLEN(XLEN), .STEP(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .op(s1_op), .shamt(s1_shamt), .data_in(s1_data_in),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready), .data_out(s1_data_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference result straight from the operation definitions
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] d, input int s);
        case (o)
            3'd0: return d << s;
            3'd1: return d >> s;
            3'd2: return $unsigned($signed(d) >>> s);
            3'd3: return (s == 0) ? d : ((d << s) | (d >> (32 - s)));
            3'd4: return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
            default: return d;
        endcase
    endfunction

    // Issue one op on the STEP=4 instance, check latency/result, hold DONE for 'hold' cycles, then drain
    task automatic run_op(input logic [2:0] o, input logic [31:0] d, input int s, input int hold);
        int lat;
        int exp_lat;
        logic [31:0] exp_d;
        exp_d   = ref_result(o, d, s);
        exp_lat = (s + STEP - 1) / STEP;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; op = o; data_in = d; shamt = 5'(s);
        @(negedge clk);
        in_valid = 1'b0; data_in = $urandom; op = 3'($urandom); shamt = 5'($urandom);
        lat = 0;
        while (!out_valid && lat < 200) begin
            check("busy_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("result", 64'(data_out), 64'(exp_d));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(data_out), 64'(exp_d));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        check("drain_valid", 64'(out_valid), 64'd0);
        check("no_accept_from_done", 64'(in_ready), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    // Start an op and abort it after two BUSY cycles with either flush or rst, in_valid held high
    task automatic abort_op(input bit use_rst);
        @(negedge clk);
        in_valid = 1'b1; op = 3'd1; data_in = 32'hFFFF_0000; shamt = 5'd20;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        in_valid = 1'b1; op = 3'd0; shamt = 5'd3; data_in = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        check(use_rst ? "rst_in_ready" : "flush_in_ready", 64'(in_ready), 64'd1);
        check(use_rst ? "rst_out_valid" : "flush_out_valid", 64'(out_valid), 64'd0);
        if (use_rst) check("rst_data_out", 64'(data_out), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_valid", 64'(out_valid), 64'd0);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; shamt = '0; data_in = '0; out_ready = 1'b0;
        s1_in_valid = 1'b0; s1_op = '0; s1_shamt = '0; s1_data_in = '0; s1_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_data_out", 64'(data_out), 64'd0);
        rst = 1'b0;

        run_op(3'd2, 32'h8000_0000, 7, 0);
        run_op(3'd1, 32'h8000_0000, 7, 0);
        run_op(3'd4, 32'h0000_00F1, 4, 1);
        run_op(3'd3, 32'h8000_0001, 1, 0);
        for (int o = 0; o < 8; o++) run_op(3'(o), 32'hDEAD_BEEF, 0, 0);
        run_op(3'd0, 32'h0000_0001, 31, 5);
        run_op(3'd6, 32'hCAFE_F00D, 13, 2);

        abort_op(1'b0);
        run_op(3'd3, 32'h1357_9BDF, 17, 0);
        abort_op(1'b1);
        run_op(3'd2, 32'h7000_0001, 31, 0);

        for (int n = 0; n < 60; n++)
            run_op(3'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));

        // STEP=1 instance: one bit per clock
        @(negedge clk);
        s1_in_valid = 1'b1; s1_op = 3'd0; s1_data_in = 32'h0000_0001; s1_shamt = 5'd31;
        @(negedge clk);
        s1_in_valid = 1'b0;
        lat = 0;
        while (!s1_out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("s1_latency", 64'(lat), 64'd31);
        check("s1_result", 64'(s1_data_out), 64'h8000_0000);
        s1_out_ready = 1'b1;
        @(negedge clk);
        check("s1_drain", 64'(s1_out_valid), 64'd0);
        check("s1_in_ready", 64'(s1_in_ready), 64'd1);
        s1_out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
